// File: rtl/note_phase_gen_if.sv
// ---------------------------------------------------------------------------
// note_phase_gen_if
// Purpose : groups the note request handshake and the per-sample phase output
//           of note_phase_gen into one bundle.
// Signals :
//   note_valid   master->slave  note request
//   note_ready   slave->master  high only while the generator is idle
//   note_code    master->slave  7-bit pitch, 12-TET, 69 = A4 = 440 Hz
//   note_rest    master->slave  1 = silence for note_dur samples
//   note_dur     master->slave  duration in sample ticks
//   stop         master->slave  abort the current note
//   sample_valid slave->master  1-cycle pulse, phase_idx/gate updated
//   phase_idx    slave->master  [7] halfwave select, [6:0] LUT address
//   gate         slave->master  1 while a pitched note sounds
//   done         slave->master  1-cycle pulse when a note's duration expires
// ---------------------------------------------------------------------------
interface note_phase_gen_if #(
    parameter int DUR_W = 16
);
    logic             note_valid;
    logic             note_ready;
    logic [6:0]       note_code;
    logic             note_rest;
    logic [DUR_W-1:0] note_dur;
    logic             stop;
    logic             sample_valid;
    logic [7:0]       phase_idx;
    logic             gate;
    logic             done;

    // Score sequencer side.
    modport master (
        output note_valid, note_code, note_rest, note_dur, stop,
        input  note_ready, sample_valid, phase_idx, gate, done
    );

    // Phase generator side.
    modport slave (
        input  note_valid, note_code, note_rest, note_dur, stop,
        output note_ready, sample_valid, phase_idx, gate, done
    );
endinterface

// File: rtl/note_phase_gen.sv
// ---------------------------------------------------------------------------
// note_phase_gen
// Purpose : accepts one note at a time, runs a fixed-rate sample tick and a
//           DDS phase accumulator, and emits an 8-bit phase index per sample
//           for the downstream sine LUT. A done pulse marks the end of each
//           note so the sequencer can queue the next one.
// Ports   :
//   clk  in  system clock, all logic on posedge
//   rst  in  synchronous, active-high reset
//   bus  note_phase_gen_if.slave (note handshake in, sample stream out)
// ---------------------------------------------------------------------------
module note_phase_gen #(
    parameter int CLK_HZ = 12_000_000,
    parameter int FS_HZ  = 48_000,
    parameter int ACC_W  = 24,
    parameter int DUR_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    note_phase_gen_if.slave bus
);

    localparam int DIV   = CLK_HZ / FS_HZ;
    localparam int CNT_W = $clog2(DIV);

    typedef logic [11:0][ACC_W-1:0] base_table_t;

    // Phase increment for semitone s in octave 10 (notes 120..131); lower
    // octaves are derived by right-shifting.
    function automatic base_table_t build_base_table();
        base_table_t tbl;
        real         f;
        tbl = '0;
        for (int s = 0; s < 12; s++) begin
            f = (2.0 ** ACC_W) * 440.0 * (2.0 ** ((51.0 + s) / 12.0)) / FS_HZ;
            tbl[s] = ACC_W'($rtoi(f + 0.5));
        end
        return tbl;
    endfunction

    // NOTE: the table is an elaboration-time constant, not storage, so it has
    // no reset; only real state registers appear in the reset branch below.
    localparam base_table_t BASE_TABLE = build_base_table();

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] incr_q, incr_d;
    logic [6:0]       code_q;
    logic             rest_q;
    logic [DUR_W-1:0] rem_q;
    logic             ready_q;
    logic             sample_valid_q;
    logic [7:0]       phase_q;
    logic             gate_q;
    logic             done_q;
    logic [3:0]       oct;
    logic [3:0]       semi;

    always_comb begin
        // NOTE: every signal written here is assigned on every pass, so no
        // path can leave one unassigned and infer a latch.
        tick   = (cnt_q == CNT_W'(DIV - 1));
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        oct    = 4'(code_q / 7'd12);
        semi   = 4'(code_q % 7'd12);
        // 7-bit codes give oct <= 10, so the shift amount never underflows.
        incr_d = BASE_TABLE[semi] >> (4'd10 - oct);
        // A rest parks the accumulator at zero so the next note starts at 0.
        acc_d  = rest_q ? '0 : acc_q + incr_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only: every register samples the
        // pre-edge values, independent of statement order in this block.
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            acc_q          <= '0;
            incr_q         <= '0;
            code_q         <= '0;
            rest_q         <= 1'b0;
            rem_q          <= '0;
            ready_q        <= 1'b1;
            sample_valid_q <= 1'b0;
            phase_q        <= '0;
            gate_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            sample_valid_q <= 1'b0;
            done_q         <= 1'b0;

            case (state_q)
                IDLE: begin
                    // Gate drops one cycle after the final sample of a note.
                    gate_q <= 1'b0;
                    // stop is ignored here; a simultaneous request is taken.
                    if (bus.note_valid && ready_q) begin
                        code_q  <= bus.note_code;
                        rest_q  <= bus.note_rest;
                        rem_q   <= bus.note_dur;
                        ready_q <= 1'b0;
                        state_q <= LOAD;
                    end
                end

                LOAD: begin
                    gate_q <= 1'b0;
                    incr_q <= incr_d;
                    if (bus.stop) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (rem_q == '0) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        state_q <= PLAY;
                    end
                end

                PLAY: begin
                    // stop outranks a coincident tick: that sample is dropped
                    // and the accumulator keeps its pre-stop value.
                    if (bus.stop) begin
                        gate_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (tick) begin
                        acc_q          <= acc_d;
                        rem_q          <= rem_q - 1'b1;
                        sample_valid_q <= 1'b1;
                        phase_q        <= acc_d[ACC_W-1 -: 8];
                        gate_q         <= !rest_q;
                        if (rem_q == DUR_W'(1)) begin
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end

                default: begin
                    gate_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.note_ready   = ready_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.phase_idx    = phase_q;
    assign bus.gate         = gate_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_note_phase_gen.sv
// ---------------------------------------------------------------------------
// tb_note_phase_gen
// Purpose : self-checking bench for note_phase_gen. A note-level model keeps
//           the DDS accumulator as a plain integer and predicts each sample's
//           phase index, gate and done, plus the sample spacing and latency.
// ---------------------------------------------------------------------------
module tb_note_phase_gen;

    localparam int CLK_HZ = 12_000_000;
    localparam int FS_HZ  = 48_000;
    localparam int ACC_W  = 24;
    localparam int DUR_W  = 16;
    localparam int DIV    = CLK_HZ / FS_HZ;

    logic clk;
    logic rst;

    int          checks;
    int          errors;
    int unsigned model_acc;
    int unsigned base_tbl [12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    note_phase_gen_if #(.DUR_W(DUR_W)) bus ();

    note_phase_gen #(
        .CLK_HZ(CLK_HZ),
        .FS_HZ (FS_HZ),
        .ACC_W (ACC_W),
        .DUR_W (DUR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ------------------------------------------------------------ model
    function automatic int unsigned model_incr(input int code);
        return base_tbl[code % 12] >> (10 - code / 12);
    endfunction

    // Advance the model by one sample tick and return the expected phase.
    function automatic logic [7:0] model_step(input bit rest, input int code);
        if (rest) model_acc = 0;
        else      model_acc = (model_acc + model_incr(code)) % (32'd1 << ACC_W);
        return 8'(model_acc >> (ACC_W - 8));
    endfunction

    // ------------------------------------------------------------ drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for the next sample_valid (at most budget edges) and reports it.
    task automatic get_sample(input int budget, output bit got, output int waited,
                              output logic [7:0] ph, output logic g, output logic d,
                              output logic rdy, output bit stray);
        got = 1'b0; waited = 0; stray = 1'b0; ph = '0; g = 1'b0; d = 1'b0; rdy = 1'b0;
        while (!got && waited < budget) begin
            step();
            waited++;
            if (bus.sample_valid === 1'b1) begin
                got = 1'b1;
                ph  = bus.phase_idx;
                g   = bus.gate;
                d   = bus.done;
                rdy = bus.note_ready;
            end else if (bus.done !== 1'b0) begin
                stray = 1'b1;
            end
        end
    endtask

    // Holds a request until the DUT takes it; returns after the accept edge.
    task automatic send_note(input int code, input bit rest, input int dur,
                             input bit with_stop, output bit ok);
        bus.note_code  = 7'(code);
        bus.note_rest  = rest;
        bus.note_dur   = DUR_W'(dur);
        bus.stop       = with_stop;
        bus.note_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 4 * DIV && !ok; i++) begin
            ok = (bus.note_ready === 1'b1);
            step();
        end
        bus.note_valid = 1'b0;
        bus.stop       = 1'b0;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        bus.note_valid = 1'b0;
        bus.note_code  = '0;
        bus.note_rest  = 1'b0;
        bus.note_dur   = '0;
        bus.stop       = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        model_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            checks++;
            if ({bus.note_ready, bus.gate, bus.sample_valid, bus.done, bus.phase_idx} !== {4'b1000, 8'h00}) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: ready=%b gate=%b sample_valid=%b done=%b phase=%0d, expected ready=1 gate=0 sample_valid=0 done=0 phase=0",
                         i, bus.note_ready, bus.gate, bus.sample_valid, bus.done, bus.phase_idx);
            end
        end
    endtask

    task automatic test_note69();
        bit ok, got, stray, last;
        int waited;
        logic [7:0] ph, exp_ph;
        logic g, d, rdy;
        send_note(69, 1'b0, 218, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL note69_accept: accepted=0, expected 1"); end
        for (int n = 0; n < 218; n++) begin
            get_sample(n == 0 ? DIV + 2 : DIV, got, waited, ph, g, d, rdy, stray);
            exp_ph = model_step(1'b0, 69);
            last   = (n == 217);
            checks++;
            if (!got || stray || (n > 0 && waited != DIV) || ph !== exp_ph || g !== 1'b1 || d !== last || (last && rdy !== 1'b1)) begin
                errors++;
                $display("FAIL note69 sample %0d: valid=%0b gap=%0d phase=%0d gate=%b done=%b ready=%b stray_done=%0b, expected gap=%0d phase=%0d gate=1 done=%0b",
                         n, got, waited, ph, g, d, rdy, stray, DIV, exp_ph, last);
            end
            if (!got) break;
        end
        // 218 * 153_791 mod 2^24 = 16_749_222 -> top byte 255.
        checks++;
        if (ph !== 8'd255) begin errors++; $display("FAIL note69_final_phase: phase=%0d, expected 255", ph); end
        step();
        checks++;
        if ({bus.gate, bus.sample_valid, bus.done, bus.note_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL note69_after_done: gate=%b sample_valid=%b done=%b ready=%b, expected 0 0 0 1",
                     bus.gate, bus.sample_valid, bus.done, bus.note_ready);
        end
    endtask

    // A rest zeroes the phase; the following pitched note starts from acc 0.
    task automatic test_rest();
        int  codes [2] = '{0, 69};
        bit  rests [2] = '{1'b1, 1'b0};
        int  durs  [2] = '{5, 3};
        bit ok, got, stray, last;
        int waited;
        logic [7:0] ph, exp_ph;
        logic g, d, rdy;
        for (int k = 0; k < 2; k++) begin
            send_note(codes[k], rests[k], durs[k], 1'b0, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rest_accept note %0d: accepted=0, expected 1", k); end
            for (int n = 0; n < durs[k]; n++) begin
                get_sample(n == 0 ? DIV + 2 : DIV, got, waited, ph, g, d, rdy, stray);
                exp_ph = model_step(rests[k], codes[k]);
                last   = (n == durs[k] - 1);
                checks++;
                if (!got || stray || (n > 0 && waited != DIV) || ph !== exp_ph || g !== !rests[k] || d !== last || (last && rdy !== 1'b1)) begin
                    errors++;
                    $display("FAIL rest note %0d sample %0d: valid=%0b gap=%0d phase=%0d gate=%b done=%b ready=%b stray_done=%0b, expected phase=%0d gate=%0b done=%0b",
                             k, n, got, waited, ph, g, d, rdy, stray, exp_ph, !rests[k], last);
                end
                if (!got) break;
            end
        end
    endtask

    task automatic test_dur_zero();
        bit ok, quiet;
        send_note(40, 1'b0, 0, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL dur0_accept: accepted=0, expected 1"); end
        step();
        checks++;
        if ({bus.done, bus.sample_valid, bus.gate, bus.note_ready} !== 4'b1001) begin
            errors++;
            $display("FAIL dur0_done: done=%b sample_valid=%b gate=%b ready=%b, expected 1 0 0 1",
                     bus.done, bus.sample_valid, bus.gate, bus.note_ready);
        end
        quiet = 1'b1;
        for (int i = 0; i < DIV + 5; i++) begin
            step();
            if (bus.sample_valid !== 1'b0 || bus.done !== 1'b0 || bus.note_ready !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL dur0_quiet: activity seen after zero-length note, expected none"); end
    endtask

    task automatic test_stop();
        bit ok, got, stray, quiet;
        int waited;
        logic [7:0] ph, exp_ph;
        logic g, d, rdy;
        send_note(81, 1'b0, 100, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stop_accept: accepted=0, expected 1"); end
        for (int n = 0; n < 10; n++) begin
            get_sample(n == 0 ? DIV + 2 : DIV, got, waited, ph, g, d, rdy, stray);
            exp_ph = model_step(1'b0, 81);
            checks++;
            if (!got || stray || (n > 0 && waited != DIV) || ph !== exp_ph || g !== 1'b1 || d !== 1'b0) begin
                errors++;
                $display("FAIL stop note81 sample %0d: valid=%0b gap=%0d phase=%0d gate=%b done=%b stray_done=%0b, expected phase=%0d gate=1 done=0",
                         n, got, waited, ph, g, d, stray, exp_ph);
            end
            if (!got) break;
        end
        // Line stop up with the 11th tick edge so that sample must be dropped.
        quiet = 1'b1;
        for (int i = 0; i < DIV - 1; i++) begin
            step();
            if (bus.sample_valid !== 1'b0 || bus.done !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL stop_pre_window: unexpected sample/done before the 11th tick, expected none"); end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        checks++;
        if ({bus.sample_valid, bus.done, bus.gate, bus.note_ready} !== 4'b0001 || bus.phase_idx !== ph) begin
            errors++;
            $display("FAIL stop_abort: sample_valid=%b done=%b gate=%b ready=%b phase=%0d, expected 0 0 0 1 phase=%0d",
                     bus.sample_valid, bus.done, bus.gate, bus.note_ready, bus.phase_idx, ph);
        end
        quiet = 1'b1;
        for (int i = 0; i < DIV + 5; i++) begin
            step();
            if (bus.sample_valid !== 1'b0 || bus.done !== 1'b0 || bus.note_ready !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL stop_post_window: activity after abort, expected idle"); end
        // stop alone in IDLE has no effect.
        bus.stop = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.note_ready !== 1'b1 || bus.done !== 1'b0 || bus.sample_valid !== 1'b0) quiet = 1'b0;
        end
        bus.stop = 1'b0;
        checks++;
        if (!quiet) begin errors++; $display("FAIL stop_idle_ignored: state changed while idle with stop, expected idle"); end
        // stop together with a request in IDLE: the request wins, and the
        // accumulator continues from where the aborted note left it.
        send_note(60, 1'b0, 4, 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stop_with_valid_accept: accepted=0, expected 1"); end
        for (int n = 0; n < 4; n++) begin
            get_sample(n == 0 ? DIV + 2 : DIV, got, waited, ph, g, d, rdy, stray);
            exp_ph = model_step(1'b0, 60);
            checks++;
            if (!got || stray || (n > 0 && waited != DIV) || ph !== exp_ph || g !== 1'b1 || d !== (n == 3)) begin
                errors++;
                $display("FAIL stop_next note60 sample %0d: valid=%0b gap=%0d phase=%0d gate=%b done=%b stray_done=%0b, expected phase=%0d gate=1 done=%0b",
                         n, got, waited, ph, g, d, stray, exp_ph, (n == 3));
            end
            if (!got) break;
        end
    endtask

    task automatic test_rst_mid();
        bit ok, got, stray;
        int waited;
        logic [7:0] ph, exp_ph;
        logic g, d, rdy;
        send_note(72, 1'b0, 50, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_mid_accept: accepted=0, expected 1"); end
        for (int n = 0; n < 3; n++) begin
            get_sample(n == 0 ? DIV + 2 : DIV, got, waited, ph, g, d, rdy, stray);
            exp_ph = model_step(1'b0, 72);
            checks++;
            if (!got || stray || (n > 0 && waited != DIV) || ph !== exp_ph || g !== 1'b1 || d !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid note72 sample %0d: valid=%0b gap=%0d phase=%0d gate=%b done=%b, expected phase=%0d gate=1 done=0",
                         n, got, waited, ph, g, d, exp_ph);
            end
            if (!got) break;
        end
        repeat ($urandom_range(0, DIV - 3)) step();
        rst = 1'b1;
        step();
        checks++;
        if ({bus.note_ready, bus.gate, bus.sample_valid, bus.done, bus.phase_idx} !== {4'b1000, 8'h00}) begin
            errors++;
            $display("FAIL rst_mid_outputs: ready=%b gate=%b sample_valid=%b done=%b phase=%0d, expected 1 0 0 0 0",
                     bus.note_ready, bus.gate, bus.sample_valid, bus.done, bus.phase_idx);
        end
        rst = 1'b0;
        model_acc = 0;
        // Accept on the first edge after release; the tick counter restarted
        // at 0, so the first sample lands DIV-1 edges after the accept edge.
        send_note(64, 1'b0, 3, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_mid_reaccept: accepted=0, expected 1"); end
        for (int n = 0; n < 3; n++) begin
            get_sample(n == 0 ? DIV + 2 : DIV, got, waited, ph, g, d, rdy, stray);
            exp_ph = model_step(1'b0, 64);
            checks++;
            if (!got || stray || waited != (n == 0 ? DIV - 1 : DIV) || ph !== exp_ph || g !== 1'b1 || d !== (n == 2)) begin
                errors++;
                $display("FAIL rst_mid note64 sample %0d: valid=%0b gap=%0d phase=%0d gate=%b done=%b stray_done=%0b, expected gap=%0d phase=%0d gate=1 done=%0b",
                         n, got, waited, ph, g, d, stray, (n == 0 ? DIV - 1 : DIV), exp_ph, (n == 2));
            end
            if (!got) break;
        end
    endtask

    // Random notes; the next request is held on the bus while the current
    // note plays and must be taken on the edge right after its done.
    task automatic test_back_to_back();
        localparam int N = 5;
        int codes [N];
        bit rests [N];
        int durs  [N];
        bit ok, got, stray, last;
        int waited;
        logic [7:0] ph, exp_ph;
        logic g, d, rdy;
        for (int k = 0; k < N; k++) begin
            codes[k] = $urandom_range(0, 127);
            rests[k] = ($urandom_range(0, 5) == 0);
            durs[k]  = $urandom_range(1, 6);
        end
        send_note(codes[0], rests[0], durs[0], 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_accept note 0: accepted=0, expected 1"); end
        for (int k = 0; k < N; k++) begin
            if (k < N - 1) begin
                bus.note_code  = 7'(codes[k+1]);
                bus.note_rest  = rests[k+1];
                bus.note_dur   = DUR_W'(durs[k+1]);
                bus.note_valid = 1'b1;
            end
            for (int n = 0; n < durs[k]; n++) begin
                get_sample(n == 0 ? DIV + 2 : DIV, got, waited, ph, g, d, rdy, stray);
                exp_ph = model_step(rests[k], codes[k]);
                last   = (n == durs[k] - 1);
                checks++;
                if (!got || stray || (n > 0 && waited != DIV) || ph !== exp_ph || g !== !rests[k] || d !== last || rdy !== last) begin
                    errors++;
                    $display("FAIL b2b note %0d (code %0d rest %0b) sample %0d: valid=%0b gap=%0d phase=%0d gate=%b done=%b ready=%b stray_done=%0b, expected phase=%0d gate=%0b done=%0b ready=%0b",
                             k, codes[k], rests[k], n, got, waited, ph, g, d, rdy, stray, exp_ph, !rests[k], last, last);
                end
                if (!got) break;
            end
            if (k < N - 1) begin
                step();
                bus.note_valid = 1'b0;
                checks++;
                if (bus.note_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_held_accept note %0d: ready=%b after done edge, expected 0", k + 1, bus.note_ready);
                end
            end
        end
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        for (int s = 0; s < 12; s++)
            base_tbl[s] = $rtoi((2.0 ** ACC_W) * 440.0 * (2.0 ** ((51.0 + s) / 12.0)) / FS_HZ + 0.5);
        test_reset();
        test_note69();
        test_rest();
        test_dur_zero();
        test_stop();
        test_rst_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run still active at time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
